// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The perf-counter ports of fetch are built only when FETCH_PERF_CNT_EN is defined.
package fetch_pkg;

    localparam int          F_TO_D_BUS_WD    = 64;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Layout of f_to_d_bus: pc in the upper word, instruction in the lower word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } f_to_d_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory channel between fetch (master) and imem (slave).
// valid/ready: a request transfers on a cycle where req_valid and req_ready are both 1; responses have no backpressure and return in order.
interface fetch_if;

    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_resp_valid_i;
    logic [31:0] imem_resp_inst_i;

    modport master (
        output imem_req_valid_o,
        output imem_req_addr_o,
        input  imem_req_ready_i,
        input  imem_resp_valid_i,
        input  imem_resp_inst_i
    );

    modport slave (
        input  imem_req_valid_o,
        input  imem_req_addr_o,
        output imem_req_ready_i,
        output imem_resp_valid_i,
        output imem_resp_inst_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with synchronous clear; used for the response queue and the PC tag queue.
// Push while full is accepted only when a pop happens in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !clear_i && full_o && !do_pop));

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues imem requests, queues responses for decode, applies redirects.
// Define FETCH_PERF_CNT_EN to add the perf_fetch_cnt / perf_redirect_cnt counters.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall_fetch,
    input  logic                     bj_taken_i,
    input  logic [31:0]              bj_target_i,
    fetch_if.master                  imem,
    output logic                     current_valid_o,
    output logic [F_TO_D_BUS_WD-1:0] f_to_d_bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              perf_fetch_cnt,
    output logic [31:0]              perf_redirect_cnt
`endif
);

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outst_q, outst_d, outst_resp;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW:0]   used_slots;

    logic          pop, req_valid, req_fire, resp_valid, keep;
    logic          resp_full, resp_empty;
    logic [CW-1:0] resp_count;
    logic [63:0]   resp_head;
    f_to_d_t       resp_entry;
    logic          tag_full, tag_empty;
    logic [CW-1:0] tag_count;
    logic [31:0]   tag_head;

    assign pop        = current_valid_o && !stall_fetch && !bj_taken_i;
    // A slot freed by this cycle's pop can be reserved again in the same cycle.
    assign used_slots = {1'b0, outst_q} + {1'b0, resp_count} - {{CW{1'b0}}, pop};
    assign req_valid  = !reset && !bj_taken_i && (used_slots < (CW+1)'(FIFO_DEPTH));
    assign req_fire   = req_valid && imem.imem_req_ready_i;
    assign resp_valid = imem.imem_resp_valid_i;
    assign keep       = resp_valid && (drop_q == '0) && !bj_taken_i;

    assign imem.imem_req_valid_o = req_valid;
    assign imem.imem_req_addr_o  = pc_q;

    assign resp_entry.pc   = tag_head;
    assign resp_entry.inst = imem.imem_resp_inst_i;

    assign current_valid_o = !resp_empty;
    assign f_to_d_bus      = resp_empty ? '0 : resp_head;

    fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tag_q (
        .clk     (clk),
        .rst     (reset),
        .push_i  (req_fire),
        .pop_i   (resp_valid),
        .clear_i (1'b0),
        .data_i  (pc_q),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (tag_count),
        .head_o  (tag_head)
    );

    fetch_fifo #(.WIDTH(F_TO_D_BUS_WD), .DEPTH(FIFO_DEPTH)) u_resp_q (
        .clk     (clk),
        .rst     (reset),
        .push_i  (keep),
        .pop_i   (pop),
        .clear_i (bj_taken_i),
        .data_i  (resp_entry),
        .full_o  (resp_full),
        .empty_o (resp_empty),
        .count_o (resp_count),
        .head_o  (resp_head)
    );

    always_comb begin
        outst_resp = outst_q;
        if (resp_valid && outst_q != '0) outst_resp = outst_q - CW'(1);
        outst_d = outst_resp;
        if (req_fire && outst_resp != CNT_MAX) outst_d = outst_resp + CW'(1);
        drop_d = drop_q;
        pc_d   = pc_q;
        if (bj_taken_i) begin
            // Every request still in flight is stale; this already covers any drops pending.
            drop_d = outst_resp;
            pc_d   = align_word(bj_target_i);
        end else begin
            if (resp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
            if (req_fire) pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_redirect_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_q    <= '0;
            perf_redirect_q <= '0;
        end else begin
            if (pop)        perf_fetch_q    <= perf_fetch_q + 32'd1;
            if (bj_taken_i) perf_redirect_q <= perf_redirect_q + 32'd1;
        end
    end

    assign perf_fetch_cnt    = perf_fetch_q;
    assign perf_redirect_cnt = perf_redirect_q;
`endif

    a_resp_has_tag: assert property (@(posedge clk) disable iff (reset) resp_valid |-> !tag_empty);
    a_tag_tracks:   assert property (@(posedge clk) disable iff (reset) tag_count == outst_q);
    a_tag_room:     assert property (@(posedge clk) disable iff (reset) req_fire |-> !tag_full);
    a_resp_room:    assert property (@(posedge clk) disable iff (reset) (keep && resp_full) |-> pop);

endmodule
